// File: rtl/lms_fir_adaptive_seq_if.sv
// lms_fir_adaptive_seq_if: sample handshake, coefficient access and result bus of the adaptive FIR
interface lms_fir_adaptive_seq_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [DATA_W-1:0]   x_in;
    logic signed [DATA_W-1:0]   d_in;
    logic [4:0]                 mu_shift;
    logic                       adapt_en;
    logic                       coef_wr_en;
    logic [$clog2(NTAPS)-1:0]   coef_addr;
    logic signed [COEF_W-1:0]   coef_wr_data;
    logic signed [COEF_W-1:0]   coef_rd_data;
    logic                       out_valid;
    logic signed [DATA_W-1:0]   y_out;
    logic signed [DATA_W-1:0]   e_out;
    logic [31:0]                iter_count;
    modport master (
        output in_valid, x_in, d_in, mu_shift, adapt_en, coef_wr_en, coef_addr, coef_wr_data,
        input  in_ready, coef_rd_data, out_valid, y_out, e_out, iter_count
    );
    modport slave (
        input  in_valid, x_in, d_in, mu_shift, adapt_en, coef_wr_en, coef_addr, coef_wr_data,
        output in_ready, coef_rd_data, out_valid, y_out, e_out, iter_count
    );
endinterface

// File: rtl/lms_fir_adaptive_seq.sv
// lms_fir_adaptive_seq: time-multiplexed LMS adaptive FIR sharing one multiplier between filter and update passes
module lms_fir_adaptive_seq #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 32,
    parameter int ACC_W  = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    lms_fir_adaptive_seq_if.slave bus
);
    localparam int IW = $clog2(NTAPS);
    localparam int MW = COEF_W > DATA_W ? COEF_W : DATA_W;
    localparam int PW = MW + DATA_W;
    localparam int SW = ACC_W > PW + 1 ? ACC_W : PW + 1;
    localparam logic signed [SW-1:0] DMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] CMAX = {{(SW-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    typedef enum logic [2:0] {IDLE, FIR, ERR, OUT, UPD} state_t;
    state_t                   r_state, w_next;
    logic signed [COEF_W-1:0] r_coef [NTAPS];
    logic signed [DATA_W-1:0] r_x [NTAPS];
    logic signed [DATA_W-1:0] r_d, r_y, r_e;
    logic [4:0]               r_mu;
    logic                     r_adapt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IW-1:0]            r_idx;
    logic [31:0]              r_iter;
    logic signed [COEF_W-1:0] r_rd;
    logic                     w_accept, w_last;
    logic signed [MW-1:0]     w_a;
    logic signed [PW-1:0]     w_p;
    logic signed [DATA_W-1:0] w_y;
    logic signed [SW-1:0]     w_ediff, w_upd;

    function automatic logic signed [DATA_W-1:0] sat_d(input logic signed [SW-1:0] v);
        return v > DMAX ? DMAX[DATA_W-1:0] : v < ~DMAX ? ~DMAX[DATA_W-1:0] : v[DATA_W-1:0];
    endfunction

    function automatic logic signed [COEF_W-1:0] sat_c(input logic signed [SW-1:0] v);
        return v > CMAX ? CMAX[COEF_W-1:0] : v < ~CMAX ? ~CMAX[COEF_W-1:0] : v[COEF_W-1:0];
    endfunction

    // The single multiplier takes coef[k] while filtering and the latched error while adapting
    assign w_accept = bus.in_valid && r_state == IDLE;
    assign w_last   = r_idx == IW'(NTAPS - 1);
    assign w_a      = r_state == UPD ? MW'(r_e) : MW'(r_coef[r_idx]);
    assign w_p      = w_a * r_x[r_idx];
    assign w_y      = sat_d(SW'(r_acc >>> (COEF_W - 1)));
    assign w_ediff  = SW'(r_d) - SW'(w_y);
    assign w_upd    = SW'(r_coef[r_idx]) + SW'(w_p >>> (DATA_W - 1 + r_mu));

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? FIR : IDLE;
            FIR:     w_next = w_last ? ERR : FIR;
            ERR:     w_next = OUT;
            OUT:     w_next = r_adapt ? UPD : IDLE;
            UPD:     w_next = w_last ? IDLE : UPD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_coef[k] <= '0;
                r_x[k]    <= '0;
            end
            r_d     <= '0;
            r_y     <= '0;
            r_e     <= '0;
            r_mu    <= '0;
            r_adapt <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_iter  <= '0;
            r_rd    <= '0;
        end else begin
            r_rd <= r_coef[bus.coef_addr];
            if (r_state == IDLE && bus.coef_wr_en)
                r_coef[bus.coef_addr] <= bus.coef_wr_data;
            if (w_accept) begin
                r_x[0] <= bus.x_in;
                for (int k = 1; k < NTAPS; k++)
                    r_x[k] <= r_x[k-1];
                r_d     <= bus.d_in;
                r_mu    <= bus.mu_shift;
                r_adapt <= bus.adapt_en;
                r_acc   <= '0;
            end
            if (r_state == FIR)
                r_acc <= r_acc + ACC_W'(w_p);
            if (r_state == FIR || r_state == UPD)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (r_state == ERR) begin
                r_y <= w_y;
                r_e <= sat_d(w_ediff);
            end
            if (r_state == UPD) begin
                r_coef[r_idx] <= sat_c(w_upd);
                if (w_last && r_iter != '1)
                    r_iter <= r_iter + 1'b1;
            end
        end
    end

    assign bus.in_ready     = r_state == IDLE;
    assign bus.out_valid    = r_state == OUT;
    assign bus.y_out        = r_y;
    assign bus.e_out        = r_e;
    assign bus.iter_count   = r_iter;
    assign bus.coef_rd_data = r_rd;
endmodule

// File: tb/tb_lms_fir_adaptive_seq.sv
// tb_lms_fir_adaptive_seq: directed and random LMS sequences checked against a reference model through a scoreboard
module tb_lms_fir_adaptive_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    lms_fir_adaptive_seq_if bus ();
    lms_fir_adaptive_seq dut (.clk(clk), .rst(rst), .bus(bus));
    int errors = 0;
    int checks = 0;
    longint m_coef [32];
    longint m_x [32];
    longint m_iter;
    longint qy [$];
    longint qe [$];
    int n_out, n_rdy;
    longint old5;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint satn(input longint v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    task automatic model(input longint x, input longint d, input int mu, input bit ad);
        longint acc, y, e;
        acc = 0;
        for (int k = 31; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = x;
        for (int k = 0; k < 32; k++) acc += m_coef[k] * m_x[k];
        y = satn(acc >>> 15);
        e = satn(d - y);
        if (ad) begin
            for (int k = 0; k < 32; k++) m_coef[k] = satn(m_coef[k] + ((e * m_x[k]) >>> (15 + mu)));
            m_iter++;
        end
        qy.push_back(y);
        qe.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.coef_wr_en = 1'b0;
        bus.coef_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            m_coef[k] = 0;
            m_x[k] = 0;
        end
        m_iter = 0;
        qy.delete();
        qe.delete();
    endtask

    task automatic wr(input int a, input longint v);
        bus.coef_wr_en = 1'b1;
        bus.coef_addr = 5'(a);
        bus.coef_wr_data = 16'(v);
        step();
        bus.coef_wr_en = 1'b0;
        m_coef[a] = v;
    endtask

    task automatic rd(input string tag, input int a, input longint exp);
        bus.coef_addr = 5'(a);
        step();
        chk(tag, bus.coef_rd_data, exp);
    endtask

    task automatic drive(input longint x, input longint d, input int mu, input bit ad);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("ready_timeout", bus.in_ready, 1);
        bus.x_in = 16'(x);
        bus.d_in = 16'(d);
        bus.mu_shift = 5'(mu);
        bus.adapt_en = ad;
        bus.in_valid = 1'b1;
        model(x, d, mu, ad);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input longint x, input longint d, input int mu, input bit ad);
        int n;
        drive(x, d, mu, ad);
        n = 1;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("out_timeout", bus.out_valid, 1);
        n_out = n;
        while (!bus.in_ready && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("idle_timeout", bus.in_ready, 1);
        n_rdy = n;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (qy.size() == 0) chk("sb_unexpected_out", bus.out_valid, 0);
            else begin
                chk("sb_y", bus.y_out, qy.pop_front());
                chk("sb_e", bus.e_out, qe.pop_front());
            end
        end
    end

    initial begin
        bus.x_in = '0;
        bus.d_in = '0;
        bus.mu_shift = '0;
        bus.adapt_en = 1'b0;
        bus.coef_wr_data = '0;
        do_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_y", bus.y_out, 0);
        chk("rst_e", bus.e_out, 0);
        for (int a = 0; a < 32; a++) rd("rst_coef_rd", a, 0);
        wr(0, 16384);
        send(1000, 0, 0, 1'b0);
        chk("t2_out_cycle", n_out, 34);
        chk("t2_ready_cycle", n_rdy, 35);
        chk("t2_y", bus.y_out, 500);
        chk("t2_e", bus.e_out, -500);
        chk("t2_iter", bus.iter_count, 0);
        do_reset();
        wr(3, 32767);
        send(8000, 0, 0, 1'b0);
        chk("t3_y1", bus.y_out, 0);
        send(0, 0, 0, 1'b0);
        send(0, 0, 0, 1'b0);
        chk("t3_y3", bus.y_out, 0);
        send(0, 0, 0, 1'b0);
        chk("t3_y4", bus.y_out, 7999);
        do_reset();
        for (int a = 0; a < 32; a++) wr(a, 32767);
        for (int i = 0; i < 32; i++) send(32767, -32768, 0, 1'b0);
        chk("t4_y_clamp", bus.y_out, 32767);
        chk("t4_e_clamp", bus.e_out, -32768);
        do_reset();
        send(16384, 8192, 4, 1'b1);
        chk("t5_out_cycle", n_out, 34);
        chk("t5_ready_cycle", n_rdy, 67);
        chk("t5_y", bus.y_out, 0);
        chk("t5_e", bus.e_out, 8192);
        chk("t5_iter", bus.iter_count, 1);
        rd("t5_coef0", 0, 256);
        rd("t5_coef1", 1, 0);
        for (int i = 0; i < 16; i++)
            send(longint'(int'($urandom_range(0, 65535)) - 32768),
                 longint'(int'($urandom_range(0, 65535)) - 32768),
                 int'($urandom_range(4, 9)), (i % 3) != 2);
        chk("rand_iter", bus.iter_count, m_iter);
        for (int a = 0; a < 32; a++) rd("rand_coef", a, m_coef[a]);
        old5 = m_coef[5];
        drive(5000, 100, 3, 1'b1);
        repeat (3) step();
        bus.coef_wr_en = 1'b1;
        bus.coef_addr = 5'd5;
        bus.coef_wr_data = 16'sd1234;
        step();
        bus.coef_wr_en = 1'b0;
        step();
        chk("t6_fir_wr_ignored", bus.coef_rd_data, old5);
        n_out = 0;
        while (!bus.out_valid && n_out < 200) begin
            step();
            n_out++;
        end
        if (n_out >= 200) chk("t6_out_timeout", bus.out_valid, 1);
        repeat (10) step();
        chk("t6_in_upd", bus.in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            m_coef[k] = 0;
            m_x[k] = 0;
        end
        chk("t6_rst_in_ready", bus.in_ready, 1);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_iter", bus.iter_count, 0);
        chk("t6_rst_y", bus.y_out, 0);
        chk("t6_rst_e", bus.e_out, 0);
        rd("t6_rst_coef5", 5, 0);
        rd("t6_rst_coef0", 0, 0);
        send(1000, 0, 0, 1'b0);
        chk("t6_post_y", bus.y_out, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
